serializer_scheduler: RTL

- Shares the single timestamp-to-scope serializer among N_CH timestamp sources.
- Round-robin arbitration between requesters; captures the winning 32-bit frame and drives the serializer's startb arm/fire sequence.
- Enforces the serializer frame duration plus an idle guard gap before the next grant.
- Sits between the per-channel timestamp logic and the serializer (frame/startb inputs), in the 250 MHz clk domain.

---
 rtl/serializer_scheduler.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/serializer_scheduler.sv
// Round-robin scheduler sharing one timestamp serializer among N_CH sources.
// Define SERSCHED_CHANNEL_TAG_EN to put the granted channel index in ser_frame[31:32-CHW].
module serializer_scheduler #(
  parameter int N_CH         = 4,
  parameter int CHW          = 2,
  parameter int ARM_CYCLES   = 2,
  parameter int FRAME_CYCLES = 42,
  parameter int GAP_CYCLES   = 8
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic [N_CH-1:0]    req_valid,
  input  logic [32*N_CH-1:0] req_data,
  output logic [N_CH-1:0]    req_ready,
  output logic               ser_startb,
  output logic [31:0]        ser_frame,
  output logic               busy,
  output logic [CHW-1:0]     last_ch,
  output logic [15:0]        frame_cnt
);

  localparam int WAIT_LEN = FRAME_CYCLES + GAP_CYCLES;
  localparam int CNT_MAX  = (WAIT_LEN > ARM_CYCLES) ? WAIT_LEN : ARM_CYCLES;
  localparam int CNTW     = $clog2(CNT_MAX + 1);
  localparam logic [CNTW-1:0] ARM_LAST  = CNTW'(ARM_CYCLES - 1);
  localparam logic [CNTW-1:0] WAIT_LAST = CNTW'(WAIT_LEN - 1);
  localparam logic [CHW-1:0]  CH_LAST   = CHW'(N_CH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [CHW-1:0]  ptr_q, ptr_d;
  logic [N_CH-1:0] ready_q, ready_d;
  logic            startb_q, startb_d;
  logic [31:0]     frame_q, frame_d;
  logic            busy_q, busy_d;
  logic [CHW-1:0]  last_q, last_d;
  logic [15:0]     fcnt_q, fcnt_d;

  logic            gnt_any_s;
  logic [CHW-1:0]  gnt_idx_s;
  logic [31:0]     gnt_data_s;
  logic [31:0]     frame_sel_s;

  // Round-robin search: walk offsets downward so the nearest valid above the pointer wins
  always_comb begin
    gnt_any_s = 1'b0;
    gnt_idx_s = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (req_valid[(int'(ptr_q) + k) % N_CH]) begin
        gnt_any_s = 1'b1;
        gnt_idx_s = CHW'((int'(ptr_q) + k) % N_CH);
      end else begin
        gnt_any_s = gnt_any_s;
      end
    end
  end

  // Frame word of the winning channel, optionally tagged with its index
  always_comb begin
    gnt_data_s = req_data[32*gnt_idx_s +: 32];
`ifdef SERSCHED_CHANNEL_TAG_EN
    frame_sel_s = {gnt_idx_s, gnt_data_s[31-CHW:0]};
`else
    frame_sel_s = gnt_data_s;
`endif
  end

  // Next-state logic for grant, arm/fire and frame-plus-gap hold-off
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    ready_d  = '0;
    startb_d = startb_q;
    frame_d  = frame_q;
    last_d   = last_q;
    fcnt_d   = fcnt_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_any_s) begin
          ready_d[gnt_idx_s] = 1'b1;
          frame_d  = frame_sel_s;
          startb_d = 1'b1;
          last_d   = gnt_idx_s;
          ptr_d    = (gnt_idx_s == CH_LAST) ? '0 : gnt_idx_s + 1'b1;
          cnt_d    = '0;
          state_d  = S_ARM;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ARM: begin
        startb_d = 1'b1;
        if (cnt_q == ARM_LAST) begin
          startb_d = 1'b0;
          fcnt_d   = fcnt_q + 16'd1;
          cnt_d    = '0;
          state_d  = S_WAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        startb_d = 1'b0;
        if (cnt_q == WAIT_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        startb_d = 1'b0;
        cnt_d    = '0;
        state_d  = S_WAIT;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset parks in WAIT so an in-flight frame drains
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q  <= S_WAIT;
      cnt_q    <= '0;
      ptr_q    <= '0;
      ready_q  <= '0;
      startb_q <= 1'b0;
      frame_q  <= 32'h0000_0000;
      busy_q   <= 1'b1;
      last_q   <= '0;
      fcnt_q   <= 16'h0000;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      ready_q  <= ready_d;
      startb_q <= startb_d;
      frame_q  <= frame_d;
      busy_q   <= busy_d;
      last_q   <= last_d;
      fcnt_q   <= fcnt_d;
    end
  end

  assign req_ready  = ready_q;
  assign ser_startb = startb_q;
  assign ser_frame  = frame_q;
  assign busy       = busy_q;
  assign last_ch    = last_q;
  assign frame_cnt  = fcnt_q;

endmodule
